// File: rtl/shift_reg_seq.sv
// Registered shift/load slice: one command per start strobe; a load completes in
// one cycle, and a serial shift or rotate moves one bit per cycle for amt cycles.
module shift_reg_seq #(
    parameter int WIDTH    = 16,
    parameter int CNT_W    = 5,
    parameter bit INV_LOAD = 1'b1
) (
    input  logic             clk_pad,
    input  logic             rst_n_pad,
    input  logic             start_pad,
    input  logic [1:0]       mode_pad,
    input  logic [CNT_W-1:0] amt_pad,
    input  logic [WIDTH-1:0] din_pad,
    input  logic             sin_pad,
    input  logic             clr_pad,
    output logic [WIDTH-1:0] q_pad,
    output logic             sout_pad,
    output logic             busy_pad,
    output logic             done_pad
);

    localparam logic [1:0] M_LOAD = 2'b00;
    localparam logic [1:0] M_SHL  = 2'b01;
    localparam logic [1:0] M_SHR  = 2'b10;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q,  mode_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   q_q,     q_d;
    logic               sout_q,  sout_d;
    logic               done_q,  done_d;

    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) begin
            state_q <= IDLE;
            mode_q  <= M_LOAD;
            cnt_q   <= '0;
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        if (clr_pad) begin
            // Clear wins over everything and aborts a shift without a done pulse.
            state_d = IDLE;
            cnt_d   = '0;
            q_d     = '0;
            sout_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_pad) begin
                        if (mode_pad == M_LOAD) begin
                            q_d    = INV_LOAD ? ~din_pad : din_pad;
                            done_d = 1'b1;
                        end else begin
                            mode_d = mode_pad;
                            if (amt_pad == '0) begin
                                done_d = 1'b1;
                            end else begin
                                cnt_d   = amt_pad;
                                state_d = SHIFT;
                            end
                        end
                    end
                end
                SHIFT: begin
                    case (mode_q)
                        M_SHL: begin
                            q_d    = {q_q[WIDTH-2:0], sin_pad};
                            sout_d = q_q[WIDTH-1];
                        end
                        M_SHR: begin
                            q_d    = {sin_pad, q_q[WIDTH-1:1]};
                            sout_d = q_q[0];
                        end
                        default: begin
                            q_d    = {q_q[0], q_q[WIDTH-1:1]};
                            sout_d = q_q[0];
                        end
                    endcase
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign q_pad    = q_q;
    assign sout_pad = sout_q;
    assign busy_pad = (state_q == SHIFT);
    assign done_pad = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Randomized bench for shift_reg_seq; each command's end result is predicted
// from the whole serial bit stream rather than cycle by cycle.
module tb_shift_reg_seq;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk_pad = 1'b0;
    logic             rst_n_pad;
    logic             start_pad;
    logic [1:0]       mode_pad;
    logic [CNT_W-1:0] amt_pad;
    logic [WIDTH-1:0] din_pad;
    logic             sin_pad;
    logic             clr_pad;
    logic [WIDTH-1:0] q_pad;
    logic             sout_pad;
    logic             busy_pad;
    logic             done_pad;

    int n_chk = 0;
    int n_err = 0;

    logic [WIDTH-1:0] q_m;
    logic             sout_m;

    shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W), .INV_LOAD(1'b1)) dut (
        .clk_pad(clk_pad), .rst_n_pad(rst_n_pad), .start_pad(start_pad),
        .mode_pad(mode_pad), .amt_pad(amt_pad), .din_pad(din_pad),
        .sin_pad(sin_pad), .clr_pad(clr_pad), .q_pad(q_pad),
        .sout_pad(sout_pad), .busy_pad(busy_pad), .done_pad(done_pad)
    );

    always #5 clk_pad = ~clk_pad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-command prediction: treat the register plus the incoming serial
    // stream as one long word and pick the window left after amt moves.
    task automatic predict(input logic [1:0] mode, input int amt, input logic sins[$]);
        logic [63:0] ext;
        if (mode == 2'b01) begin
            ext = 64'(q_m) << amt;
            for (int k = 0; k < amt; k++) ext = ext | (64'(sins[k]) << (amt - 1 - k));
            q_m    = ext[WIDTH-1:0];
            sout_m = ext[WIDTH];
        end else if (mode == 2'b10) begin
            ext = 64'(q_m);
            for (int k = 0; k < amt; k++) ext = ext | (64'(sins[k]) << (WIDTH + k));
            sout_m = ext[amt-1];
            ext    = ext >> amt;
            q_m    = ext[WIDTH-1:0];
        end else begin
            int r;
            r      = amt % WIDTH;
            sout_m = q_m[(amt - 1) % WIDTH];
            ext    = {32'b0, q_m, q_m};
            ext    = ext >> r;
            q_m    = ext[WIDTH-1:0];
        end
    endtask

    // sinv: 0/1 fixed serial input, 2 random. inject: pulse a load start while busy.
    task automatic do_cmd(input logic [1:0] mode, input int amt, input logic [WIDTH-1:0] din,
                          input int sinv, input bit inject);
        logic sins[$];
        int   nb;
        logic s;
        @(negedge clk_pad);
        start_pad = 1'b1; mode_pad = mode; amt_pad = CNT_W'(amt); din_pad = din;
        @(negedge clk_pad);
        start_pad = 1'b0; mode_pad = 2'($urandom); amt_pad = CNT_W'($urandom); din_pad = WIDTH'($urandom);
        if (mode == 2'b00) begin
            q_m = ~din;
            chk("load_q", 64'(q_pad), 64'(q_m));
            chk("load_done", 64'(done_pad), 64'd1);
            chk("load_busy", 64'(busy_pad), 64'd0);
        end else if (amt == 0) begin
            chk("amt0_q", 64'(q_pad), 64'(q_m));
            chk("amt0_sout", 64'(sout_pad), 64'(sout_m));
            chk("amt0_done", 64'(done_pad), 64'd1);
            chk("amt0_busy", 64'(busy_pad), 64'd0);
        end else begin
            nb = 0;
            while (busy_pad && nb < 100) begin
                chk("busy_nodone", 64'(done_pad), 64'd0);
                if (inject && nb == 0 && amt >= 2) begin
                    start_pad = 1'b1; mode_pad = 2'b00; din_pad = WIDTH'($urandom);
                end else begin
                    start_pad = 1'b0;
                end
                s = (sinv == 2) ? 1'($urandom) : 1'(sinv);
                sin_pad = s;
                sins.push_back(s);
                @(negedge clk_pad);
                nb++;
            end
            start_pad = 1'b0;
            predict(mode, amt, sins);
            chk("busy_cycles", 64'(nb), 64'(amt));
            chk("shift_done", 64'(done_pad), 64'd1);
            chk("shift_q", 64'(q_pad), 64'(q_m));
            chk("shift_sout", 64'(sout_pad), 64'(sout_m));
        end
        @(negedge clk_pad);
        chk("done_pulse_end", 64'(done_pad), 64'd0);
        chk("idle_busy", 64'(busy_pad), 64'd0);
    endtask

    initial begin
        rst_n_pad = 1'b0; start_pad = 1'b0; mode_pad = 2'b00; amt_pad = '0;
        din_pad = '0; sin_pad = 1'b0; clr_pad = 1'b0;
        q_m = '0; sout_m = 1'b0;
        #1;
        chk("rst_q", 64'(q_pad), 64'd0);
        chk("rst_sout", 64'(sout_pad), 64'd0);
        chk("rst_busy", 64'(busy_pad), 64'd0);
        chk("rst_done", 64'(done_pad), 64'd0);
        @(negedge clk_pad); @(negedge clk_pad);
        rst_n_pad = 1'b1;

        // Directed cases from the block's intended use.
        do_cmd(2'b00, 0, 16'h00FF, 0, 1'b0);
        chk("dir_load", 64'(q_pad), 64'hFF00);
        q_m = 16'h7FFE;
        do_cmd(2'b00, 0, 16'h7FFE, 0, 1'b0);
        do_cmd(2'b01, 3, '0, 1, 1'b0);
        chk("dir_shl", 64'(q_pad), 64'h000F);
        chk("dir_shl_sout", 64'(sout_pad), 64'd0);
        do_cmd(2'b00, 0, 16'hFFFE, 0, 1'b0);
        do_cmd(2'b11, 17, '0, 0, 1'b0);
        chk("dir_rotr17", 64'(q_pad), 64'h8000);
        do_cmd(2'b10, 0, '0, 0, 1'b0);
        do_cmd(2'b10, 20, '0, 2, 1'b1);

        // Clear on the second busy cycle of a 5-cycle shift.
        do_cmd(2'b00, 0, 16'h1234, 0, 1'b0);
        @(negedge clk_pad);
        start_pad = 1'b1; mode_pad = 2'b01; amt_pad = 5'd5;
        @(negedge clk_pad);
        start_pad = 1'b0;
        chk("clr_pre_busy", 64'(busy_pad), 64'd1);
        sin_pad = 1'b1;
        @(negedge clk_pad);
        clr_pad = 1'b1;
        @(negedge clk_pad);
        clr_pad = 1'b0;
        q_m = '0; sout_m = 1'b0;
        chk("clr_q", 64'(q_pad), 64'd0);
        chk("clr_sout", 64'(sout_pad), 64'd0);
        chk("clr_busy", 64'(busy_pad), 64'd0);
        chk("clr_done", 64'(done_pad), 64'd0);
        @(negedge clk_pad);
        chk("clr_nodone", 64'(done_pad), 64'd0);

        // Asynchronous reset in the middle of a shift.
        do_cmd(2'b00, 0, 16'h0F0F, 0, 1'b0);
        @(negedge clk_pad);
        start_pad = 1'b1; mode_pad = 2'b11; amt_pad = 5'd9;
        @(negedge clk_pad);
        start_pad = 1'b0;
        @(negedge clk_pad);
        rst_n_pad = 1'b0;
        #1;
        chk("arst_q", 64'(q_pad), 64'd0);
        chk("arst_sout", 64'(sout_pad), 64'd0);
        chk("arst_busy", 64'(busy_pad), 64'd0);
        chk("arst_done", 64'(done_pad), 64'd0);
        q_m = '0; sout_m = 1'b0;
        @(negedge clk_pad);
        rst_n_pad = 1'b1;
        do_cmd(2'b00, 0, 16'hA5A5, 0, 1'b0);
        chk("arst_reload", 64'(q_pad), 64'h5A5A);

        // Random command mix.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] m;
            int         a;
            m = 2'($urandom);
            a = (($urandom % 4) == 0) ? 0 : int'($urandom_range(1, 31));
            do_cmd(m, a, WIDTH'($urandom), 2, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
